// File: rtl/ram_master.sv
// ram_master: single-port bus initiator for a synchronous RAM that shares
// a tri-state data bus. Writes take one bus cycle; reads take an address
// cycle, a data cycle and a turnaround cycle before the bus is free again.
module ram_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_cs,
  output logic              mem_rw
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    TURN    = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                cs_nx;
  logic                rw_nx;
  logic                drive;
  logic                drive_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   wdata_nx;
  logic                handshake;

  // Ready only while idle and out of reset, so no request is taken in reset.
  assign req_ready = (state == IDLE) && reset_n;
  assign handshake = req_valid && req_ready;

  // The block only ever drives the bus during the single write cycle.
  assign mem_data = drive ? wdata : {DATA_W{1'bz}};

  // Next state plus the next value of every registered bus control output.
  always_comb begin
    state_nx = state;
    cs_nx    = 1'b0;
    rw_nx    = 1'b0;
    drive_nx = 1'b0;
    addr_nx  = mem_address;
    wdata_nx = wdata;
    case (state)
      IDLE: begin
        if (handshake) begin
          addr_nx = req_addr;
          cs_nx   = 1'b1;
          if (req_we) begin
            state_nx = WRITE;
            rw_nx    = 1'b1;
            drive_nx = 1'b1;
            wdata_nx = req_wdata;
          end else begin
            state_nx = RD_ADDR;
          end
        end
      end
      WRITE:   state_nx = IDLE;
      RD_ADDR: begin
        state_nx = RD_DATA;
        cs_nx    = 1'b1;
      end
      // Chip select drops for the turnaround so the RAM releases the bus
      // a full cycle before any following write can drive it.
      RD_DATA: state_nx = TURN;
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and bus control registers; reset aborts any transaction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mem_cs      <= 1'b0;
      mem_rw      <= 1'b0;
      drive       <= 1'b0;
      mem_address <= '0;
    end else begin
      state       <= state_nx;
      mem_cs      <= cs_nx;
      mem_rw      <= rw_nx;
      drive       <= drive_nx;
      mem_address <= addr_nx;
    end
  end

  // Write data holding register; it only reaches the bus when drive is set.
  always_ff @(posedge clock) begin
    wdata <= wdata_nx;
  end

  // Read capture at the end of the data cycle; the pulse covers TURN only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state == RD_DATA);
      if (state == RD_DATA) begin
        rsp_rdata <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: drives ram_master against a behavioural synchronous RAM and
// checks bus timing and read data against a transaction-level memory model.
module tb_ram_master;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clock;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_address;
  wire  [DW-1:0] mem_data;
  logic          mem_cs;
  logic          mem_rw;

  // RAM device attached to the bus
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;

  // Reference model: what every address should hold after completed writes
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [AW-1:0] waddr[$];
  logic [DW-1:0] last_wdata;
  logic [DW-1:0] last_rsp;
  bit            have_wr;
  int            nvec;
  int            nerr;

  ram_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_rw(mem_rw)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_cs && mem_rw) ram[mem_address] <= mem_data;
    if (mem_cs && !mem_rw) ram_q <= ram[mem_address];
  end
  assign mem_data = (mem_cs && !mem_rw) ? ram_q : {DW{1'bz}};

  // Inputs presented while the block is busy: junk, optionally with valid held
  task automatic drive_busy(input bit hold);
    req_valid = hold;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL wr_ready_idle got %b exp 1", req_ready); end
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clock);
    drive_busy(hold);
    nvec++; if (mem_cs !== 1'b1) begin nerr++; $display("FAIL wr_cs got %b exp 1", mem_cs); end
    nvec++; if (mem_rw !== 1'b1) begin nerr++; $display("FAIL wr_rw got %b exp 1", mem_rw); end
    nvec++; if (mem_address !== a) begin nerr++; $display("FAIL wr_addr got %h exp %h", mem_address, a); end
    nvec++; if (mem_data !== d) begin nerr++; $display("FAIL wr_data got %h exp %h", mem_data, d); end
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL wr_ready_busy got %b exp 0", req_ready); end
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL wr_rsp_valid got %b exp 0", rsp_valid); end
    nvec++; if (rsp_rdata !== last_rsp) begin nerr++; $display("FAIL wr_rsp_hold got %h exp %h", rsp_rdata, last_rsp); end
    ref_mem[a] = d; last_wdata = d; have_wr = 1'b1; waddr.push_back(a);
    @(negedge clock);
    nvec++; if (mem_cs !== 1'b0) begin nerr++; $display("FAIL wr_after_cs got %b exp 0", mem_cs); end
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL wr_after_ready got %b exp 1", req_ready); end
    nvec++; if (mem_data === d) begin nerr++; $display("FAIL wr_after_release got %h exp Z", mem_data); end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input bit hold, output time t_rsp);
    logic [DW-1:0] e;
    e = ref_mem[a];
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rd_ready_idle got %b exp 1", req_ready); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = DW'($urandom);
    @(negedge clock);
    drive_busy(hold);
    nvec++; if (mem_cs !== 1'b1 || mem_rw !== 1'b0) begin nerr++; $display("FAIL rda_ctl got cs=%b rw=%b exp cs=1 rw=0", mem_cs, mem_rw); end
    nvec++; if (mem_address !== a) begin nerr++; $display("FAIL rda_addr got %h exp %h", mem_address, a); end
    nvec++; if (mem_data !== ram_q) begin nerr++; $display("FAIL rda_contention got %h exp %h", mem_data, ram_q); end
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rda_rsp_valid got %b exp 0", rsp_valid); end
    nvec++; if (rsp_rdata !== last_rsp) begin nerr++; $display("FAIL rda_rsp_hold got %h exp %h", rsp_rdata, last_rsp); end
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL rda_ready got %b exp 0", req_ready); end
    @(negedge clock);
    drive_busy(hold);
    nvec++; if (mem_cs !== 1'b1 || mem_rw !== 1'b0) begin nerr++; $display("FAIL rdd_ctl got cs=%b rw=%b exp cs=1 rw=0", mem_cs, mem_rw); end
    nvec++; if (mem_address !== a) begin nerr++; $display("FAIL rdd_addr got %h exp %h", mem_address, a); end
    nvec++; if (mem_data !== e) begin nerr++; $display("FAIL rdd_bus got %h exp %h", mem_data, e); end
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rdd_rsp_valid got %b exp 0", rsp_valid); end
    nvec++; if (rsp_rdata !== last_rsp) begin nerr++; $display("FAIL rdd_rsp_hold got %h exp %h", rsp_rdata, last_rsp); end
    @(negedge clock);
    drive_busy(hold);
    t_rsp = $time;
    nvec++; if (rsp_valid !== 1'b1) begin nerr++; $display("FAIL turn_rsp_valid got %b exp 1", rsp_valid); end
    nvec++; if (rsp_rdata !== e) begin nerr++; $display("FAIL turn_rdata addr %h got %h exp %h", a, rsp_rdata, e); end
    nvec++; if (mem_cs !== 1'b0) begin nerr++; $display("FAIL turn_cs got %b exp 0", mem_cs); end
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL turn_ready got %b exp 0", req_ready); end
    if (have_wr) begin
      nvec++; if (mem_data === last_wdata) begin nerr++; $display("FAIL turn_bus got %h exp Z", mem_data); end
    end
    last_rsp = e;
    @(negedge clock);
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rd_idle_rsp_valid got %b exp 0", rsp_valid); end
    nvec++; if (rsp_rdata !== e) begin nerr++; $display("FAIL rd_idle_rdata got %h exp %h", rsp_rdata, e); end
    nvec++; if (req_ready !== 1'b1 || mem_cs !== 1'b0) begin nerr++; $display("FAIL rd_idle got ready=%b cs=%b exp 1/0", req_ready, mem_cs); end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h155; req_wdata = 8'h33;
    #1 reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready got %b exp 0", req_ready); end
      nvec++; if (mem_cs !== 1'b0 || mem_rw !== 1'b0) begin nerr++; $display("FAIL rst_ctl got cs=%b rw=%b exp 0/0", mem_cs, mem_rw); end
      nvec++; if (mem_address !== '0) begin nerr++; $display("FAIL rst_addr got %h exp 0", mem_address); end
      nvec++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0) begin nerr++; $display("FAIL rst_rsp got v=%b d=%h exp 0/00", rsp_valid, rsp_rdata); end
    end
    reset_n = 1'b1; req_valid = 1'b0;
    #1;
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
    @(negedge clock);
    nvec++; if (mem_cs !== 1'b0) begin nerr++; $display("FAIL rst_idle_cs got %b exp 0", mem_cs); end
  endtask

  task automatic test_write_read_top();
    time t;
    do_write(10'h3FF, 8'h5A, 1'b0);
    do_read(10'h3FF, 1'b0, t);
    req_valid = 1'b0;
  endtask

  task automatic test_read_then_write();
    time t;
    do_write(10'h001, 8'h3C, 1'b0);
    do_read(10'h001, 1'b0, t);
    do_write(10'h001, 8'hC3, 1'b0);
    do_read(10'h001, 1'b0, t);
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    time t1, t2;
    do_write(10'h000, 8'hA5, 1'b0);
    do_read(10'h000, 1'b0, t1);
    do_read(10'h000, 1'b0, t2);
    req_valid = 1'b0;
    nvec++; if (t2 - t1 !== 40) begin nerr++; $display("FAIL b2b_spacing got %0t exp 40", t2 - t1); end
  endtask

  task automatic test_reset_in_rd_data();
    time t;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h001;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    nvec++; if (mem_cs !== 1'b1) begin nerr++; $display("FAIL abort_pre_cs got %b exp 1", mem_cs); end
    reset_n = 1'b0; req_valid = 1'b1;
    #1;
    nvec++; if (mem_cs !== 1'b0 || mem_rw !== 1'b0) begin nerr++; $display("FAIL abort_ctl got cs=%b rw=%b exp 0/0", mem_cs, mem_rw); end
    nvec++; if (mem_data === last_wdata) begin nerr++; $display("FAIL abort_bus got %h exp Z", mem_data); end
    nvec++; if (rsp_rdata !== '0) begin nerr++; $display("FAIL abort_rdata got %h exp 00", rsp_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL abort_rsp_valid got %b exp 0", rsp_valid); end
      nvec++; if (req_ready !== 1'b0 || mem_cs !== 1'b0) begin nerr++; $display("FAIL abort_hold got ready=%b cs=%b exp 0/0", req_ready, mem_cs); end
    end
    reset_n = 1'b1;
    last_rsp = '0;
    #1;
    do_read(10'h3FF, 1'b1, t);
    req_valid = 1'b0;
  endtask

  task automatic test_hold_valid();
    time t;
    do_write(10'h2AA, 8'h69, 1'b1);
    do_write(10'h155, 8'h96, 1'b1);
    do_read(10'h2AA, 1'b1, t);
    do_read(10'h155, 1'b1, t);
    req_valid = 1'b0;
  endtask

  task automatic test_random();
    time t;
    int r;
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0 || waddr.size() == 0) begin
        do_write(AW'($urandom), DW'($urandom_range(1, 254)), 1'($urandom));
      end else if (r == 3) begin
        drive_busy(1'b0);
        @(negedge clock);
        nvec++; if (mem_cs !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin nerr++; $display("FAIL idle_gap got cs=%b ready=%b v=%b exp 0/1/0", mem_cs, req_ready, rsp_valid); end
      end else begin
        do_read(waddr[$urandom_range(0, waddr.size() - 1)], 1'($urandom), t);
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    nvec = 0; nerr = 0; have_wr = 1'b0; last_wdata = '0; last_rsp = '0;
    test_reset();
    test_write_read_top();
    test_read_then_write();
    test_back_to_back();
    test_reset_in_rd_data();
    test_hold_valid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
